// File: rtl/mem_access_if.sv
// EX/MEM -> MEM/WB bus of the MEM stage: pipeline inputs driven by the master,
// registered MEM/WB results returned by the slave.
interface mem_access_if;
  logic        stall;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic [4:0]  rd_in;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic        mem_to_reg_out;
  logic        reg_write_out;
  logic [4:0]  rd_out;
  logic        misaligned_out;

  // Pipeline bus, no handshake: the master presents a new EX/MEM record every
  // cycle and stall=1 tells the slave to ignore it and hold its MEM/WB latch.
  modport master (
    output stall, alu_result, write_data, mem_read, mem_write, mem_size,
           mem_unsigned, reg_write_in, mem_to_reg_in, rd_in,
    input  read_data_out, alu_result_out, mem_to_reg_out, reg_write_out,
           rd_out, misaligned_out
  );

  modport slave (
    input  stall, alu_result, write_data, mem_read, mem_write, mem_size,
           mem_unsigned, reg_write_in, mem_to_reg_in, rd_in,
    output read_data_out, alu_result_out, mem_to_reg_out, reg_write_out,
           rd_out, misaligned_out
  );
endinterface

// File: rtl/mem_access.sv
// MEM stage: little-endian byte/half/word data memory with extension,
// misalignment detection and a stallable MEM/WB latch.
module mem_access #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 8
) (
  input logic         clk,
  input logic         rst,
  mem_access_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int DW    = DATA_WIDTH;

  logic [DW-1:0] mem_q [DEPTH];

  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           byte_off;
  logic                 is_half, is_word, access, misaligned, do_load, do_store;
  logic [DW-1:0]        cur_word, load_ext, store_word;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;

  logic [DW-1:0] rdata_d, rdata_q, alu_d, alu_q;
  logic          m2r_d, m2r_q, rw_d, rw_q, mis_d, mis_q;
  logic [4:0]    rd_d, rd_q;

  assign word_idx = bus.alu_result[ADDR_BITS+1:2];
  assign byte_off = bus.alu_result[1:0];

  always_comb begin
    is_half    = (bus.mem_size == 2'b01);
    is_word    = bus.mem_size[1];
    access     = bus.mem_read | bus.mem_write;
    misaligned = access & ((is_half & byte_off[0]) | (is_word & (byte_off != 2'b00)));
    // A simultaneous read+write is a store only.
    do_load    = bus.mem_read & ~bus.mem_write & ~misaligned;
    do_store   = bus.mem_write & ~misaligned & ~bus.stall;

    cur_word = mem_q[word_idx];
    ld_byte  = cur_word[{byte_off, 3'b000} +: 8];
    ld_half  = byte_off[1] ? cur_word[31:16] : cur_word[15:0];

    case (bus.mem_size)
      2'b00:   load_ext = {{24{~bus.mem_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{~bus.mem_unsigned & ld_half[15]}}, ld_half};
      default: load_ext = cur_word;
    endcase

    store_word = cur_word;
    case (bus.mem_size)
      2'b00: store_word[{byte_off, 3'b000} +: 8] = bus.write_data[7:0];
      2'b01: begin
        if (byte_off[1]) store_word[31:16] = bus.write_data[15:0];
        else             store_word[15:0]  = bus.write_data[15:0];
      end
      default: store_word = bus.write_data;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    alu_d   = alu_q;
    m2r_d   = m2r_q;
    rw_d    = rw_q;
    rd_d    = rd_q;
    mis_d   = mis_q;
    if (!bus.stall) begin
      rdata_d = do_load ? load_ext : '0;
      alu_d   = bus.alu_result;
      m2r_d   = bus.mem_to_reg_in;
      rw_d    = bus.reg_write_in & ~misaligned;
      rd_d    = bus.rd_in;
      mis_d   = misaligned;
    end
  end

  // The memory shares this block so that an edge seen while rst=1 never stores;
  // the array itself is deliberately not cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      alu_q   <= '0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      m2r_q   <= m2r_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      if (do_store) mem_q[word_idx] <= store_word;
    end
  end

  assign bus.read_data_out  = rdata_q;
  assign bus.alu_result_out = alu_q;
  assign bus.mem_to_reg_out = m2r_q;
  assign bus.reg_write_out  = rw_q;
  assign bus.rd_out         = rd_q;
  assign bus.misaligned_out = mis_q;
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, hand-written reset/stall
// sequences, and random traffic against a byte-array memory model.
module tb_mem_access;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_if bus();
  mem_access dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic        rwin;
    logic        m2r;
    logic [4:0]  rdreg;
  } op_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] alu;
    logic        m2r;
    logic        rw;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t e;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] bm [1024];
  exp_t mexp;

  function automatic op_t mkop(logic [31:0] addr, logic [31:0] wdata, logic rd, logic wr,
                               logic [1:0] size, logic uns, logic rwin, logic m2r, logic [4:0] rdreg);
    op_t o;
    o.addr = addr; o.wdata = wdata; o.rd = rd; o.wr = wr; o.size = size;
    o.uns = uns; o.rwin = rwin; o.m2r = m2r; o.rdreg = rdreg;
    return o;
  endfunction

  function automatic exp_t mkexp(logic [31:0] data, logic [31:0] alu, logic m2r, logic rw,
                                 logic [4:0] rd, logic mis);
    exp_t e;
    e.data = data; e.alu = alu; e.m2r = m2r; e.rw = rw; e.rd = rd; e.mis = mis;
    return e;
  endfunction

  // Pass-through fields of a directed vector follow its own inputs.
  function automatic vec_t mkvec(op_t o, logic [31:0] data, logic rw, logic mis);
    vec_t v;
    v.op = o;
    v.e  = mkexp(data, o.addr, o.m2r, rw, o.rdreg, mis);
    return v;
  endfunction

  // Reference model: 1 KiB byte array, little-endian, address taken modulo 1024.
  function automatic void model_step(op_t op, logic st);
    int nb, a;
    logic mis;
    logic [31:0] val;
    if (rst) begin
      mexp = mkexp(0, 0, 0, 0, 0, 0);
      return;
    end
    if (st) return;
    nb  = (op.size == 2'd0) ? 1 : (op.size == 2'd1) ? 2 : 4;
    a   = int'(op.addr & 32'h3FF);
    mis = (op.rd | op.wr) && (a % nb != 0);
    val = 0;
    if (op.rd && !op.wr && !mis) begin
      for (int i = 0; i < nb; i++) val = val | (32'(bm[a+i]) << (8*i));
      if (!op.uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
    end
    mexp = mkexp(val, op.addr, op.m2r, op.rwin && !mis, op.rdreg, mis);
    if (op.wr && !mis)
      for (int i = 0; i < nb; i++) bm[a+i] = 8'(op.wdata >> (8*i));
  endfunction

  task automatic step(input op_t op, input logic st);
    @(negedge clk);
    bus.stall         = st;
    bus.alu_result    = op.addr;
    bus.write_data    = op.wdata;
    bus.mem_read      = op.rd;
    bus.mem_write     = op.wr;
    bus.mem_size      = op.size;
    bus.mem_unsigned  = op.uns;
    bus.reg_write_in  = op.rwin;
    bus.mem_to_reg_in = op.m2r;
    bus.rd_in         = op.rdreg;
    @(posedge clk);
    model_step(op, st);
    #1;
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".read_data"},  bus.read_data_out,        e.data);
    chk({tag, ".alu_result"}, bus.alu_result_out,       e.alu);
    chk({tag, ".mem_to_reg"}, 32'(bus.mem_to_reg_out),  32'(e.m2r));
    chk({tag, ".reg_write"},  32'(bus.reg_write_out),   32'(e.rw));
    chk({tag, ".rd"},         32'(bus.rd_out),          32'(e.rd));
    chk({tag, ".misaligned"}, 32'(bus.misaligned_out),  32'(e.mis));
  endtask

  vec_t vt [$];
  exp_t zero_e, hold_e;
  op_t  op;

  initial begin
    zero_e = mkexp(0, 0, 0, 0, 0, 0);
    //              addr          wdata         rd wr size uns rw m2r rd      data          rw mis
    vt.push_back(mkvec(mkop(32'h10, 32'hDEAD_BEEF, 0, 1, 2'd2, 0, 0, 0, 5'd0),  32'h0,          0, 0));
    vt.push_back(mkvec(mkop(32'h10, 32'h0,         1, 0, 2'd2, 0, 1, 1, 5'd8),  32'hDEAD_BEEF,  1, 0));
    vt.push_back(mkvec(mkop(32'h20, 32'h0,         0, 1, 2'd2, 0, 0, 0, 5'd0),  32'h0,          0, 0));
    vt.push_back(mkvec(mkop(32'h21, 32'hABCD_EF80, 0, 1, 2'd0, 0, 0, 0, 5'd0),  32'h0,          0, 0));
    vt.push_back(mkvec(mkop(32'h21, 32'h0,         1, 0, 2'd0, 0, 1, 1, 5'd9),  32'hFFFF_FF80,  1, 0));
    vt.push_back(mkvec(mkop(32'h21, 32'h0,         1, 0, 2'd0, 1, 1, 1, 5'd10), 32'h0000_0080,  1, 0));
    vt.push_back(mkvec(mkop(32'h20, 32'h0,         1, 0, 2'd2, 0, 1, 1, 5'd11), 32'h0000_8000,  1, 0));
    vt.push_back(mkvec(mkop(32'h30, 32'h0,         0, 1, 2'd2, 0, 0, 0, 5'd0),  32'h0,          0, 0));
    vt.push_back(mkvec(mkop(32'h32, 32'hFFFF_1234, 0, 1, 2'd1, 0, 0, 0, 5'd0),  32'h0,          0, 0));
    vt.push_back(mkvec(mkop(32'h32, 32'h0,         1, 0, 2'd1, 1, 1, 1, 5'd12), 32'h0000_1234,  1, 0));
    vt.push_back(mkvec(mkop(32'h31, 32'h0,         1, 0, 2'd1, 0, 1, 1, 5'd13), 32'h0,          0, 1));
    vt.push_back(mkvec(mkop(32'h30, 32'h0000_8001, 0, 1, 2'd1, 0, 0, 0, 5'd0),  32'h0,          0, 0));
    vt.push_back(mkvec(mkop(32'h30, 32'h0,         1, 0, 2'd1, 0, 1, 1, 5'd14), 32'hFFFF_8001,  1, 0));
    vt.push_back(mkvec(mkop(32'h30, 32'h0,         1, 0, 2'd2, 0, 1, 0, 5'd15), 32'h1234_8001,  1, 0));
    vt.push_back(mkvec(mkop(32'h40, 32'h1111_1111, 0, 1, 2'd2, 0, 0, 0, 5'd0),  32'h0,          0, 0));
    vt.push_back(mkvec(mkop(32'h42, 32'h2222_2222, 0, 1, 2'd2, 0, 1, 0, 5'd0),  32'h0,          0, 1));
    vt.push_back(mkvec(mkop(32'h42, 32'h0,         1, 0, 2'd3, 0, 1, 1, 5'd16), 32'h0,          0, 1));
    vt.push_back(mkvec(mkop(32'h40, 32'h0,         1, 0, 2'd2, 0, 1, 1, 5'd17), 32'h1111_1111,  1, 0));
    vt.push_back(mkvec(mkop(32'h43, 32'hFFFF_FFFF, 0, 0, 2'd2, 0, 1, 0, 5'd18), 32'h0,          1, 0));
    vt.push_back(mkvec(mkop(32'h0,  32'hA5A5_A5A5, 0, 1, 2'd2, 0, 0, 0, 5'd0),  32'h0,          0, 0));
    vt.push_back(mkvec(mkop(32'h400,32'h0,         1, 0, 2'd2, 0, 1, 1, 5'd19), 32'hA5A5_A5A5,  1, 0));
    vt.push_back(mkvec(mkop(32'h0,  32'h0,         1, 0, 2'd2, 0, 1, 1, 5'd20), 32'hA5A5_A5A5,  1, 0));
    vt.push_back(mkvec(mkop(32'h0,  32'h5A5A_5A5A, 0, 1, 2'd2, 0, 0, 0, 5'd0),  32'h0,          0, 0));
    vt.push_back(mkvec(mkop(32'h0,  32'h7777_7777, 1, 1, 2'd2, 0, 1, 1, 5'd21), 32'h0,          1, 0));
    vt.push_back(mkvec(mkop(32'h0,  32'h0,         1, 0, 2'd2, 0, 1, 1, 5'd22), 32'h7777_7777,  1, 0));
    vt.push_back(mkvec(mkop(32'h50, 32'h0000_0099, 0, 1, 2'd2, 0, 0, 0, 5'd0),  32'h0,          0, 0));

    op = mkop(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.stall = 1'b0;
    step(op, 1'b0);
    check_all("reset_state", zero_e);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].op, 1'b0);
      check_all($sformatf("vec%0d", i), vt[i].e);
    end

    // Stall: latch frozen and the presented store is dropped.
    hold_e = mkexp(32'hDEAD_BEEF, 32'h10, 1, 1, 5'd3, 0);
    step(mkop(32'h10, 0, 1, 0, 2'd2, 0, 1, 1, 5'd3), 1'b0);
    check_all("pre_stall", hold_e);
    for (int i = 0; i < 3; i++) begin
      step(mkop(32'h50, 32'h55, 0, 1, 2'd2, 0, 1, 0, 5'd7), 1'b1);
      check_all($sformatf("stall%0d", i), hold_e);
    end
    step(mkop(32'h50, 0, 1, 0, 2'd2, 0, 1, 1, 5'd4), 1'b0);
    check_all("after_stall", mkexp(32'h99, 32'h50, 1, 1, 5'd4, 0));
    step(mkop(32'h50, 32'h55, 0, 1, 2'd2, 0, 1, 0, 5'd7), 1'b0);
    check_all("unstalled_sw", mkexp(32'h0, 32'h50, 0, 1, 5'd7, 0));
    step(mkop(32'h50, 0, 1, 0, 2'd2, 0, 1, 1, 5'd5), 1'b0);
    check_all("sw_landed", mkexp(32'h55, 32'h50, 1, 1, 5'd5, 0));

    // Asynchronous reset mid-cycle; a store seen under reset must not land.
    step(mkop(32'h10, 0, 1, 0, 2'd2, 0, 1, 1, 5'd6), 1'b0);
    check_all("pre_reset", mkexp(32'hDEAD_BEEF, 32'h10, 1, 1, 5'd6, 0));
    #2 rst = 1'b1;
    #1 check_all("async_reset", zero_e);
    step(mkop(32'h10, 32'h0BAD_F00D, 0, 1, 2'd2, 0, 1, 1, 5'd6), 1'b1);
    check_all("reset_held", zero_e);
    @(negedge clk);
    rst = 1'b0;
    step(mkop(32'h10, 0, 1, 0, 2'd2, 0, 1, 1, 5'd2), 1'b0);
    check_all("mem_kept", mkexp(32'hDEAD_BEEF, 32'h10, 1, 1, 5'd2, 0));

    // Random traffic confined to words 0x40..0x4F, upper address bits random.
    for (int w = 0; w < 16; w++)
      step(mkop(32'h100 + 32'(4*w), $urandom, 0, 1, 2'd2, 0, 0, 0, 5'd0), 1'b0);
    for (int i = 0; i < 400; i++) begin
      op = mkop(($urandom & 32'hFFFF_FC00) | 32'h100 | 32'($urandom_range(0, 63)),
                $urandom, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 5'($urandom));
      step(op, $urandom_range(0, 9) == 0);
      check_all($sformatf("rand%0d", i), mexp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
